vtg_pattern_gen: RTL and testbench
==================================

Name: vtg_pattern_gen

Overview:
- Parametrised video timing and test-pattern generator for the DVI/HDMI TX path.
- Drives DE/HS/VS plus RGB directly into the TMDS encoder. Runs in the pixel clock domain.
- Three resolution presets are selectable at run time. Switching takes effect only at a frame boundary.
- Supports configurable colour depth, sync polarity, and either automatic or manual pattern cycling based on a frame counter.

Parameters:
- DATA_W, 8: bits per colour channel; must be >= 8.
- DEF_RES, 2: timing preset loaded at reset (0..3).
- HS_POL, 1: HS active level (1 = positive).
- VS_POL, 1: VS active level (1 = positive).
- FRAME_SHIFT, 8: in auto mode, the pattern advances every 2^FRAME_SHIFT frames.

Ports:
- I_clk  in  1  pixel clock.
- I_rst_n  in  1  reset.
- I_res_sel  in  2  timing preset request.
- I_auto  in  1  1 = pattern taken from frame counter; 0 = pattern taken from I_mode.
- I_mode  in  3  manual pattern select.
- I_sqr_width  in  16  checker square size in pixels; 0 is treated as 1.
- I_single_r/g/b  in  DATA_W each  colour used by the single-colour pattern.
- O_de  out  1  data enable.
- O_hs  out  1  horizontal sync, level per HS_POL.
- O_vs  out  1  vertical sync, level per VS_POL.
- O_r/O_g/O_b  out  DATA_W each  pixel data.
- O_frame_cnt  out  16  completed-frame counter.
- O_mode  out  3  pattern currently displayed.

Behaviour:
- Reset: I_rst_n is asynchronous, active-low; the block is clocked on I_clk.
- Reset values:
  - h_cnt = 0, v_cnt = 0.
  - Active preset = DEF_RES.
  - O_de = 0; O_hs = ~HS_POL; O_vs = ~VS_POL.
  - RGB = 0; O_frame_cnt = 0; O_mode = 0.
- Presets (h_total, h_sync, h_bp, h_res, v_total, v_sync, v_bp, v_res, bar_w):
  - 0: 1056, 128, 88, 800, 628, 4, 23, 600, 100.
  - 1: 1344, 136, 160, 1024, 806, 6, 29, 768, 128.
  - 2: 1650, 40, 220, 1280, 750, 5, 20, 720, 160.
  - 3: reserved; behaves as 2.
- Counters:
  - h_cnt runs 0..h_total-1 and then wraps.
  - v_cnt increments when h_cnt wraps and runs 0..v_total-1.
- Sync and enable, as functions of the counters:
  - hs_act = h_cnt < h_sync.
  - vs_act = v_cnt < v_sync.
  - de = (h_sync+h_bp <= h_cnt < h_sync+h_bp+h_res) AND the same condition on v_cnt.
- Coordinates: x = h_cnt - (h_sync+h_bp) and y = v_cnt - (v_sync+v_bp), both valid while de = 1.
- Output registration and latency:
  - All outputs are registered.
  - O_de, O_hs, O_vs and RGB are mutually aligned.
  - Latency from the counters to the outputs is fixed at 2 cycles.
- Frame boundary event: h_cnt = h_total-1 and v_cnt = v_total-1. On that event:
  - I_res_sel is latched into the active preset, and the counters wrap to 0 under the new preset.
  - O_frame_cnt increments, wrapping at 0xFFFF -> 0.
  - A change to I_res_sel at any other time has no effect until the next boundary.
- Pattern select:
  - Auto mode: pattern = O_frame_cnt[FRAME_SHIFT+2:FRAME_SHIFT].
  - Manual mode: pattern = I_mode.
  - The selection, and O_mode, update only at the frame boundary, so no frame shows two patterns.
- Patterns (FS = all ones in DATA_W):
  - 0, colour bar: 8 bars of bar_w pixels, in order white, yellow, cyan, green, magenta, red, blue, black. A bar index counter advances when the in-bar count reaches bar_w-1. No divider is used.
  - 1, grid: FS white when x[4:0] = 0 or y[4:0] = 0; otherwise black.
  - 2, gray ramp: R = G = B = {x[7:0], (DATA_W-8) zeros}.
  - 3, single colour: I_single_r/g/b.
  - 4, checker: square index toggles every I_sqr_width pixels in x and y; the pixel is white when the x-parity XOR y-parity = 0, black otherwise. Parity resets at each line start (x) and frame start (y).
  - 5..7: behave as 0..2 respectively.
- Blanking: RGB = 0 whenever O_de = 0.
- I_sqr_width: sampled at the frame boundary.
- Reset mid-frame: all state returns to reset values immediately. Timing restarts from h_cnt = v_cnt = 0 with preset DEF_RES.

Test Plan:
- Reset, then release with I_res_sel = 2:
  - O_hs period is 1650 clocks; O_hs high for 40 clocks.
  - O_de high for 1280 clocks, rising 260 clocks after the O_hs rising edge.
  - 720 DE lines per frame; O_vs high for 5 lines; frame period 1237500 clocks.
- Switch I_res_sel 2 -> 0 mid-frame:
  - The current frame completes at 1650x750.
  - The next frame has 1056-clock lines, 800 DE pixels and 600 DE lines.
  - O_frame_cnt increments by 1 across the switch.
- Manual mode, I_mode = 0, preset 2:
  - Pixel 0 = (FS, FS, FS); pixel 160 = (FS, FS, 0); pixel 1279 = (0, 0, 0).
  - With DATA_W = 10, FS = 0x3FF.
- I_auto = 1, FRAME_SHIFT = 1:
  - O_mode sequence 0, 0, 1, 1, 2, 2, ... changes only at the frame boundary.
  - O_frame_cnt wraps 0xFFFF -> 0 (force the counter to check the wrap).
- Checker with I_sqr_width = 0, and with 30:
  - Width 0 gives alternating single pixels.
  - Width 30 gives colour flips at x = 30 and x = 60, and at y = 30.
  - HS_POL = 0 inverts the O_hs level only.
- Assert I_rst_n low mid-line, then release:
  - Outputs take reset values immediately and asynchronously.
  - After release, the first O_de rises at the same offset as in the first scenario.

Source files
------------

// File: rtl/vtg_pattern_gen.sv
// Video timing generator with built-in test patterns for the DVI/HDMI TX path.
// Counters -> stage-1 (sync/enable/coordinates) -> stage-2 (colour) gives a fixed 2-cycle latency.
module vtg_pattern_gen #(
  parameter int DATA_W      = 8,
  parameter int DEF_RES     = 2,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1,
  parameter int FRAME_SHIFT = 8
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic [1:0]        I_res_sel,
  input  logic              I_auto,
  input  logic [2:0]        I_mode,
  input  logic [15:0]       I_sqr_width,
  input  logic [DATA_W-1:0] I_single_r,
  input  logic [DATA_W-1:0] I_single_g,
  input  logic [DATA_W-1:0] I_single_b,
  output logic              O_de,
  output logic              O_hs,
  output logic              O_vs,
  output logic [DATA_W-1:0] O_r,
  output logic [DATA_W-1:0] O_g,
  output logic [DATA_W-1:0] O_b,
  output logic [15:0]       O_frame_cnt,
  output logic [2:0]        O_mode
);

  localparam logic              HS_ON = 1'(HS_POL);
  localparam logic              VS_ON = 1'(VS_POL);
  localparam logic [DATA_W-1:0] FS    = {DATA_W{1'b1}};

  logic [1:0]  r_res;
  logic [10:0] r_h_cnt, r_v_cnt;
  logic [15:0] r_frame_cnt;
  logic [2:0]  r_pat;
  logic [15:0] r_sqr_w;

  logic [10:0] w_h_total, w_h_sync, w_h_bp, w_h_res;
  logic [10:0] w_v_total, w_v_sync, w_v_bp, w_v_res;
  logic [7:0]  w_bar_w;

  always_comb begin
    w_h_total = 11'd1650; w_h_sync = 11'd40; w_h_bp = 11'd220; w_h_res = 11'd1280;
    w_v_total = 11'd750;  w_v_sync = 11'd5;  w_v_bp = 11'd20;  w_v_res = 11'd720;
    w_bar_w   = 8'd160;
    case (r_res)
      2'd0: begin
        w_h_total = 11'd1056; w_h_sync = 11'd128; w_h_bp = 11'd88; w_h_res = 11'd800;
        w_v_total = 11'd628;  w_v_sync = 11'd4;   w_v_bp = 11'd23; w_v_res = 11'd600;
        w_bar_w   = 8'd100;
      end
      2'd1: begin
        w_h_total = 11'd1344; w_h_sync = 11'd136; w_h_bp = 11'd160; w_h_res = 11'd1024;
        w_v_total = 11'd806;  w_v_sync = 11'd6;   w_v_bp = 11'd29;  w_v_res = 11'd768;
        w_bar_w   = 8'd128;
      end
      default: ;
    endcase
  end

  logic [10:0] w_h_start, w_h_end, w_v_start, w_v_end;
  logic        w_h_last, w_v_last, w_frame_end, w_h_act, w_v_act, w_de;
  logic [7:0]  w_x;
  logic [4:0]  w_y;
  logic [15:0] w_frame_nxt, w_sqr_m1;

  assign w_h_start   = w_h_sync + w_h_bp;
  assign w_h_end     = w_h_start + w_h_res;
  assign w_v_start   = w_v_sync + w_v_bp;
  assign w_v_end     = w_v_start + w_v_res;
  assign w_h_last    = (r_h_cnt == w_h_total - 11'd1);
  assign w_v_last    = (r_v_cnt == w_v_total - 11'd1);
  assign w_frame_end = w_h_last & w_v_last;
  assign w_h_act     = (r_h_cnt >= w_h_start) && (r_h_cnt < w_h_end);
  assign w_v_act     = (r_v_cnt >= w_v_start) && (r_v_cnt < w_v_end);
  assign w_de        = w_h_act & w_v_act;
  assign w_x         = 8'(r_h_cnt - w_h_start);
  assign w_y         = 5'(r_v_cnt - w_v_start);
  assign w_frame_nxt = r_frame_cnt + 16'd1;
  // A square width of 0 behaves as 1, i.e. the parity flips every pixel.
  assign w_sqr_m1    = (r_sqr_w == 16'd0) ? 16'd0 : r_sqr_w - 16'd1;

  assign O_frame_cnt = r_frame_cnt;
  assign O_mode      = r_pat;

  // Preset, pattern and square width change only on the frame boundary.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_res       <= 2'(DEF_RES);
      r_frame_cnt <= '0;
      r_pat       <= '0;
      r_sqr_w     <= '0;
    end else begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end
      if (w_frame_end) begin
        r_res       <= I_res_sel;
        r_frame_cnt <= w_frame_nxt;
        r_pat       <= I_auto ? w_frame_nxt[FRAME_SHIFT+2:FRAME_SHIFT] : I_mode;
        r_sqr_w     <= I_sqr_width;
      end
    end
  end

  // Bar and checker trackers hold the value for the pixel at the current counters.
  logic [7:0]  r_bar_cnt;
  logic [2:0]  r_bar_idx;
  logic [15:0] r_cx_cnt, r_cy_cnt;
  logic        r_cx_par, r_cy_par;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      r_cx_cnt  <= '0;
      r_cx_par  <= 1'b0;
      r_cy_cnt  <= '0;
      r_cy_par  <= 1'b0;
    end else begin
      if (!w_de) begin
        r_bar_cnt <= '0;
        r_bar_idx <= '0;
        r_cx_cnt  <= '0;
        r_cx_par  <= 1'b0;
      end else begin
        if (r_bar_cnt == w_bar_w - 8'd1) begin
          r_bar_cnt <= '0;
          r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
          r_bar_cnt <= r_bar_cnt + 8'd1;
        end
        if (r_cx_cnt == w_sqr_m1) begin
          r_cx_cnt <= '0;
          r_cx_par <= ~r_cx_par;
        end else begin
          r_cx_cnt <= r_cx_cnt + 16'd1;
        end
      end
      if (!w_v_act) begin
        r_cy_cnt <= '0;
        r_cy_par <= 1'b0;
      end else if (w_h_last) begin
        if (r_cy_cnt == w_sqr_m1) begin
          r_cy_cnt <= '0;
          r_cy_par <= ~r_cy_par;
        end else begin
          r_cy_cnt <= r_cy_cnt + 16'd1;
        end
      end
    end
  end

  logic       r_s1_de, r_s1_hs, r_s1_vs, r_s1_chk;
  logic [7:0] r_s1_x;
  logic [4:0] r_s1_y;
  logic [2:0] r_s1_bar;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_s1_de  <= 1'b0;
      r_s1_hs  <= 1'b0;
      r_s1_vs  <= 1'b0;
      r_s1_chk <= 1'b0;
      r_s1_x   <= '0;
      r_s1_y   <= '0;
      r_s1_bar <= '0;
    end else begin
      r_s1_de  <= w_de;
      r_s1_hs  <= (r_h_cnt < w_h_sync);
      r_s1_vs  <= (r_v_cnt < w_v_sync);
      r_s1_chk <= r_cx_par ^ r_cy_par;
      r_s1_x   <= w_x;
      r_s1_y   <= w_y;
      r_s1_bar <= r_bar_idx;
    end
  end

  logic [DATA_W-1:0] w_r, w_g, w_b, w_ramp;

  assign w_ramp = DATA_W'(r_s1_x) << (DATA_W - 8);

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to index bits directly.
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (r_pat)
      3'd0, 3'd5: begin
        w_r = {DATA_W{~r_s1_bar[1]}};
        w_g = {DATA_W{~r_s1_bar[2]}};
        w_b = {DATA_W{~r_s1_bar[0]}};
      end
      3'd1, 3'd6: begin
        if ((r_s1_x[4:0] == 5'd0) || (r_s1_y == 5'd0)) begin
          w_r = FS;
          w_g = FS;
          w_b = FS;
        end
      end
      3'd2, 3'd7: begin
        w_r = w_ramp;
        w_g = w_ramp;
        w_b = w_ramp;
      end
      3'd3: begin
        w_r = I_single_r;
        w_g = I_single_g;
        w_b = I_single_b;
      end
      default: begin
        if (!r_s1_chk) begin
          w_r = FS;
          w_g = FS;
          w_b = FS;
        end
      end
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_de <= 1'b0;
      O_hs <= ~HS_ON;
      O_vs <= ~VS_ON;
      O_r  <= '0;
      O_g  <= '0;
      O_b  <= '0;
    end else begin
      O_de <= r_s1_de;
      O_hs <= r_s1_hs ? HS_ON : ~HS_ON;
      O_vs <= r_s1_vs ? VS_ON : ~VS_ON;
      O_r  <= r_s1_de ? w_r : '0;
      O_g  <= r_s1_de ? w_g : '0;
      O_b  <= r_s1_de ? w_b : '0;
    end
  end

endmodule

// File: tb/tb_vtg_pattern_gen.sv
// Directed bench for vtg_pattern_gen; long blanking stretches are skipped by loading the
// timing counters directly, so every expected value is quoted relative to that load point.
module tb_vtg_pattern_gen;

  localparam int DW = 10;
  localparam logic [DW-1:0] FS = 10'h3FF;

  logic          I_clk, I_rst_n;
  logic [1:0]    I_res_sel;
  logic          I_auto;
  logic [2:0]    I_mode;
  logic [15:0]   I_sqr_width;
  logic [DW-1:0] I_single_r, I_single_g, I_single_b;
  logic          O_de, O_hs, O_vs;
  logic [DW-1:0] O_r, O_g, O_b;
  logic [15:0]   O_frame_cnt;
  logic [2:0]    O_mode;
  logic          n_de, n_hs, n_vs;
  logic [DW-1:0] n_r, n_g, n_b;
  logic [15:0]   n_frame;
  logic [2:0]    n_mode;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  vtg_pattern_gen #(.DATA_W(DW), .DEF_RES(2), .HS_POL(1), .VS_POL(1), .FRAME_SHIFT(1)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_res_sel(I_res_sel), .I_auto(I_auto), .I_mode(I_mode),
    .I_sqr_width(I_sqr_width), .I_single_r(I_single_r), .I_single_g(I_single_g),
    .I_single_b(I_single_b), .O_de(O_de), .O_hs(O_hs), .O_vs(O_vs), .O_r(O_r), .O_g(O_g),
    .O_b(O_b), .O_frame_cnt(O_frame_cnt), .O_mode(O_mode)
  );

  vtg_pattern_gen #(.DATA_W(DW), .DEF_RES(2), .HS_POL(0), .VS_POL(0), .FRAME_SHIFT(1)) dut_n (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_res_sel(I_res_sel), .I_auto(I_auto), .I_mode(I_mode),
    .I_sqr_width(I_sqr_width), .I_single_r(I_single_r), .I_single_g(I_single_g),
    .I_single_b(I_single_b), .O_de(n_de), .O_hs(n_hs), .O_vs(n_vs), .O_r(n_r), .O_g(n_g),
    .O_b(n_b), .O_frame_cnt(n_frame), .O_mode(n_mode)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_rgb(input string tag, input logic [DW-1:0] r, g, b);
    check(tag, {O_r, O_g, O_b}, {r, g, b});
  endtask

  // Advance on falling edges; after n rising edges the outputs show counter position n-2.
  task automatic step_to(input int c);
    while (cyc < c) begin
      @(negedge I_clk);
      cyc++;
    end
  endtask

  task automatic jump(input int h, input int v);
    dut.r_h_cnt = 11'(h);
    dut.r_v_cnt = 11'(v);
    cyc = 0;
  endtask

  // Frame boundary under the 1056x628 preset, 6 rising edges after loading (1050, 627).
  task automatic boundary(input logic [15:0] exp_frame, input logic [2:0] old_mode,
                          input logic [2:0] new_mode);
    jump(1050, 627);
    step_to(5);
    check("mode_before_boundary", O_mode, old_mode);
    step_to(6);
    check("frame_after_boundary", O_frame_cnt, exp_frame);
    check("mode_after_boundary", O_mode, new_mode);
  endtask

  initial begin
    logic [2:0] exp_m [5];
    logic [2:0] prev_m;
    exp_m = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
    I_rst_n = 1'b0; I_res_sel = 2'd2; I_auto = 1'b0; I_mode = 3'd0; I_sqr_width = 16'd30;
    I_single_r = 10'h123; I_single_g = 10'h2AB; I_single_b = 10'h055;
    repeat (3) @(negedge I_clk);
    check("rst_de", O_de, 1'b0);
    check("rst_hs", O_hs, 1'b0);
    check("rst_vs", O_vs, 1'b0);
    check_rgb("rst_rgb", 0, 0, 0);
    check("rst_frame", O_frame_cnt, 16'd0);
    check("rst_mode", O_mode, 3'd0);
    check("rst_neg_sync", {n_hs, n_vs}, 2'b11);
    check("rst_neg_misc", {n_de, n_r, n_g, n_b, n_frame, n_mode}, 64'd0);
    I_rst_n = 1'b1;
    cyc = 0;

    // 1650x750 timing from reset, line 0 onwards
    step_to(2);
    check("a_hs_start", O_hs, 1'b1);
    check("a_vs_start", O_vs, 1'b1);
    check("a_neg_sync", {n_hs, n_vs}, 2'b00);
    step_to(2 + 39);   check("a_hs_39", O_hs, 1'b1);
    step_to(2 + 40);   check("a_hs_40", O_hs, 1'b0);
    check("a_neg_hs_40", n_hs, 1'b1);
    step_to(2 + 300);  check("a_vblank_de", O_de, 1'b0);
    step_to(2 + 1649); check("a_hs_1649", O_hs, 1'b0);
    step_to(2 + 1650); check("a_hs_period", O_hs, 1'b1);
    step_to(2 + 4 * 1650 + 100); check("a_vs_line4", O_vs, 1'b1);
    step_to(2 + 5 * 1650);       check("a_vs_line5", O_vs, 1'b0);
    jump(0, 24);
    step_to(2 + 1650 + 259); check("a_de_259", O_de, 1'b0);
    step_to(2 + 1650 + 260); check("a_de_260", O_de, 1'b1);
    check_rgb("a_bar_px0", FS, FS, FS);
    step_to(2 + 1650 + 260 + 159);  check_rgb("a_bar_px159", FS, FS, FS);
    step_to(2 + 1650 + 260 + 160);  check_rgb("a_bar_px160", FS, FS, 0);
    step_to(2 + 1650 + 260 + 320);  check_rgb("a_bar_px320", 0, FS, FS);
    step_to(2 + 1650 + 260 + 1279); check_rgb("a_bar_px1279", 0, 0, 0);
    check("a_de_1279", O_de, 1'b1);
    step_to(2 + 1650 + 260 + 1280); check("a_de_1280", O_de, 1'b0);

    // Preset request mid-frame; current 1650-wide frame must still complete
    I_res_sel = 2'd0;
    jump(1640, 749);
    step_to(9);  check("b_frame_before", O_frame_cnt, 16'd0);
    step_to(10); check("b_frame_after", O_frame_cnt, 16'd1);
    check("b_mode", O_mode, 3'd0);
    step_to(11); check("b_old_last_px", {O_hs, O_vs}, 2'b00);
    step_to(12); check("b_new_first_px", {O_hs, O_vs}, 2'b11);
    step_to(12 + 127);  check("b_hs_127", O_hs, 1'b1);
    step_to(12 + 128);  check("b_hs_128", O_hs, 1'b0);
    step_to(12 + 1055); check("b_hs_1055", O_hs, 1'b0);
    step_to(12 + 1056); check("b_hs_period", O_hs, 1'b1);
    jump(0, 26);  step_to(2 + 216);  check("b_de_line26", O_de, 1'b0);
    jump(0, 27);
    step_to(2 + 215);  check("b_de_215", O_de, 1'b0);
    step_to(2 + 216);  check("b_de_216", O_de, 1'b1);
    check_rgb("b_bar_px0", FS, FS, FS);
    step_to(2 + 316);  check_rgb("b_bar_px100", FS, FS, 0);
    step_to(2 + 1015); check("b_de_1015", O_de, 1'b1);
    step_to(2 + 1016); check("b_de_1016", O_de, 1'b0);
    jump(0, 626); step_to(2 + 216); check("b_de_line626", O_de, 1'b1);
    jump(0, 627); step_to(2 + 216); check("b_de_line627", O_de, 1'b0);

    // Grid
    I_mode = 3'd1;
    boundary(16'd2, 3'd0, 3'd1);
    jump(0, 28);
    step_to(2 + 216); check_rgb("c_grid_x0", FS, FS, FS);
    step_to(2 + 217); check_rgb("c_grid_x1", 0, 0, 0);
    step_to(2 + 247); check_rgb("c_grid_x31", 0, 0, 0);
    step_to(2 + 248); check_rgb("c_grid_x32", FS, FS, FS);
    jump(0, 59);
    step_to(2 + 221); check_rgb("c_grid_y32", FS, FS, FS);

    // Gray ramp
    I_mode = 3'd2;
    boundary(16'd3, 3'd1, 3'd2);
    jump(0, 27);
    step_to(2 + 216); check_rgb("d_ramp_x0", 0, 0, 0);
    step_to(2 + 221); check_rgb("d_ramp_x5", 10'h014, 10'h014, 10'h014);
    step_to(2 + 471); check_rgb("d_ramp_x255", 10'h3FC, 10'h3FC, 10'h3FC);
    step_to(2 + 472); check_rgb("d_ramp_x256", 0, 0, 0);

    // Single colour and blanking
    I_mode = 3'd3;
    boundary(16'd4, 3'd2, 3'd3);
    jump(0, 27);
    step_to(2 + 100); check_rgb("e_blank", 0, 0, 0);
    step_to(2 + 300); check_rgb("e_single", 10'h123, 10'h2AB, 10'h055);

    // Checker, width 0 -> single-pixel squares
    I_mode = 3'd4;
    I_sqr_width = 16'd0;
    boundary(16'd5, 3'd3, 3'd4);
    jump(0, 26);
    step_to(1056 + 2 + 216); check_rgb("f_chk_x0", FS, FS, FS);
    step_to(1056 + 2 + 217); check_rgb("f_chk_x1", 0, 0, 0);
    step_to(1056 + 2 + 218); check_rgb("f_chk_x2", FS, FS, FS);
    step_to(2112 + 2 + 216); check_rgb("f_chk_y1_x0", 0, 0, 0);
    step_to(2112 + 2 + 217); check_rgb("f_chk_y1_x1", FS, FS, FS);

    // Checker, width 30
    I_sqr_width = 16'd30;
    boundary(16'd6, 3'd4, 3'd4);
    jump(0, 26);
    step_to(1056 + 2 + 245); check_rgb("g_chk_x29", FS, FS, FS);
    step_to(1056 + 2 + 246); check_rgb("g_chk_x30", 0, 0, 0);
    step_to(1056 + 2 + 275); check_rgb("g_chk_x59", 0, 0, 0);
    step_to(1056 + 2 + 276); check_rgb("g_chk_x60", FS, FS, FS);
    step_to(30 * 1056 + 2 + 216); check_rgb("g_chk_y29", FS, FS, FS);
    step_to(31 * 1056 + 2 + 216); check_rgb("g_chk_y30_x0", 0, 0, 0);
    step_to(31 * 1056 + 2 + 246); check_rgb("g_chk_y30_x30", FS, FS, FS);

    // Auto pattern from frame counter, including the 0xFFFF wrap
    I_auto = 1'b1;
    dut.r_frame_cnt = 16'hFFFE;
    boundary(16'hFFFF, 3'd4, 3'd7);
    prev_m = 3'd7;
    for (int i = 0; i < 5; i++) begin
      boundary(16'(i), prev_m, exp_m[i]);
      prev_m = exp_m[i];
    end

    // Asynchronous reset mid-line
    jump(0, 27);
    step_to(2 + 400);
    check("i_pre_de", O_de, 1'b1);
    check_rgb("i_pre_ramp_x184", 10'h2E0, 10'h2E0, 10'h2E0);
    I_rst_n = 1'b0;
    #1;
    check("i_rst_sync", {O_de, O_hs, O_vs}, 3'b000);
    check_rgb("i_rst_rgb", 0, 0, 0);
    check("i_rst_frame", O_frame_cnt, 16'd0);
    check("i_rst_mode", O_mode, 3'd0);
    @(negedge I_clk);
    I_rst_n = 1'b1;
    I_auto = 1'b0;
    I_mode = 3'd0;
    cyc = 0;
    step_to(2);        check("i_hs_start", {O_hs, O_vs}, 2'b11);
    step_to(2 + 40);   check("i_hs_40", O_hs, 1'b0);
    step_to(2 + 1056); check("i_hs_1056", O_hs, 1'b0);
    step_to(2 + 1650); check("i_hs_period", O_hs, 1'b1);
    jump(0, 25);
    step_to(2 + 259);  check("i_de_259", O_de, 1'b0);
    step_to(2 + 260);  check("i_de_260", O_de, 1'b1);
    check_rgb("i_bar_px0", FS, FS, FS);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
